// File: rtl/udp_tx_scheduler_if.sv
// Bundle between the payload sources / UDP coder and the TX scheduler.
// The master modport is the scheduler's view; slave is the sources-plus-coder side.
interface udp_tx_scheduler_if;
    logic [1:0]  SRC_REQ;
    logic [15:0] SRC_DST_PORT0;
    logic [15:0] SRC_DST_PORT1;
    logic [15:0] SRC_LEN0;
    logic [15:0] SRC_LEN1;
    logic [15:0] SRC_CSUM0;
    logic [15:0] SRC_CSUM1;
    logic [7:0]  SRC_DATA0;
    logic [7:0]  SRC_DATA1;
    logic [1:0]  SRC_GNT;
    logic [1:0]  SRC_RD;
    logic [1:0]  SRC_ERR;
    logic        UDP_EN;
    logic [63:0] UDP_HEADER;
    logic [15:0] IN_DATA_LENGTH;
    logic [15:0] UDP_DATA_CHECKSUM;
    logic        UDP_DATA_REQUEST;
    logic [7:0]  IN_DATA;
    logic        IN_DATA_VLD;
    logic        UDP_DONE;
    logic        BUSY;

    modport master (
        input  SRC_REQ, SRC_DST_PORT0, SRC_DST_PORT1, SRC_LEN0, SRC_LEN1,
               SRC_CSUM0, SRC_CSUM1, SRC_DATA0, SRC_DATA1,
               UDP_DATA_REQUEST, UDP_DONE,
        output SRC_GNT, SRC_RD, SRC_ERR, UDP_EN, UDP_HEADER, IN_DATA_LENGTH,
               UDP_DATA_CHECKSUM, IN_DATA, IN_DATA_VLD, BUSY
    );

    modport slave (
        output SRC_REQ, SRC_DST_PORT0, SRC_DST_PORT1, SRC_LEN0, SRC_LEN1,
               SRC_CSUM0, SRC_CSUM1, SRC_DATA0, SRC_DATA1,
               UDP_DATA_REQUEST, UDP_DONE,
        input  SRC_GNT, SRC_RD, SRC_ERR, UDP_EN, UDP_HEADER, IN_DATA_LENGTH,
               UDP_DATA_CHECKSUM, IN_DATA, IN_DATA_VLD, BUSY
    );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP coder between two payload sources:
// grant, start pulse, payload streaming, done/timeout handling and inter-frame gap.
module udp_tx_scheduler #(
    parameter logic [15:0] MAX_LEN    = 16'd1472,
    parameter logic [7:0]  GAP_CYCLES = 8'd12,
    parameter logic [15:0] DONE_TMO   = 16'd2047
) (
    input  logic               CLK,
    input  logic               RST,
    udp_tx_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_REQ,
        S_STREAM,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t      state_reg, state_next;
    logic        ptr_reg, ptr_next;
    logic        owner_reg, owner_next;
    logic [15:0] port_reg, port_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] csum_reg, csum_next;
    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;
    logic [1:0]  gnt_reg, gnt_next;
    logic [1:0]  err_reg, err_next;
    logic        udp_en_reg, udp_en_next;
    logic [7:0]  in_data_reg, in_data_next;
    logic        in_vld_reg, in_vld_next;

    logic        rd_any;
    logic        win;
    logic        tmo_hit;
    logic [15:0] req_port [2];
    logic [15:0] req_len  [2];
    logic [15:0] req_csum [2];
    logic [7:0]  req_data [2];

    assign req_port[0] = bus.SRC_DST_PORT0;
    assign req_port[1] = bus.SRC_DST_PORT1;
    assign req_len[0]  = bus.SRC_LEN0;
    assign req_len[1]  = bus.SRC_LEN1;
    assign req_csum[0] = bus.SRC_CSUM0;
    assign req_csum[1] = bus.SRC_CSUM1;
    assign req_data[0] = bus.SRC_DATA0;
    assign req_data[1] = bus.SRC_DATA1;

    // Pointer source wins if it is requesting, otherwise the other one.
    assign win     = bus.SRC_REQ[ptr_reg] ? ptr_reg : ~ptr_reg;
    assign tmo_hit = ({1'b0, tmo_cnt_reg} + 17'd1) >= {1'b0, DONE_TMO};

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        port_next     = port_reg;
        len_next      = len_reg;
        csum_next     = csum_reg;
        byte_cnt_next = byte_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        gnt_next      = 2'b00;
        err_next      = 2'b00;
        udp_en_next   = 1'b0;
        rd_any        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // A grant pulse still on the bus blocks re-arbitration for one
                // cycle so a just-rejected request is not seen a second time.
                if ((|bus.SRC_REQ) && (gnt_reg == 2'b00)) begin
                    gnt_next[win] = 1'b1;
                    if (req_len[win] > MAX_LEN) begin
                        err_next[win] = 1'b1;
                    end else begin
                        owner_next = win;
                        port_next  = req_port[win];
                        len_next   = req_len[win];
                        csum_next  = req_csum[win];
                        ptr_next   = ~win;
                        state_next = S_START;
                    end
                end
            end
            S_START: begin
                udp_en_next = 1'b1;
                state_next  = S_WAIT_REQ;
            end
            S_WAIT_REQ: begin
                if (bus.UDP_DATA_REQUEST) begin
                    tmo_cnt_next = 16'd0;
                    if (len_reg == 16'd0) begin
                        state_next = S_WAIT_DONE;
                    end else begin
                        // First read happens in the request cycle itself.
                        rd_any        = 1'b1;
                        byte_cnt_next = len_reg - 16'd1;
                        state_next    = (len_reg == 16'd1) ? S_WAIT_DONE : S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                rd_any = 1'b1;
                if (byte_cnt_reg != 16'd0) begin
                    byte_cnt_next = byte_cnt_reg - 16'd1;
                end
                if (byte_cnt_reg <= 16'd1) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.UDP_DONE) begin
                    gap_cnt_next = 8'd0;
                    state_next   = S_GAP;
                end else if (tmo_hit) begin
                    err_next[owner_reg] = 1'b1;
                    gap_cnt_next        = 8'd0;
                    state_next          = S_GAP;
                end else if (tmo_cnt_reg != 16'hFFFF) begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg >= GAP_CYCLES) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        in_vld_next  = rd_any;
        in_data_next = rd_any ? req_data[owner_reg] : 8'h00;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= 1'b0;
            owner_reg    <= 1'b0;
            port_reg     <= 16'd0;
            len_reg      <= 16'd0;
            csum_reg     <= 16'd0;
            byte_cnt_reg <= 16'd0;
            tmo_cnt_reg  <= 16'd0;
            gap_cnt_reg  <= 8'd0;
            gnt_reg      <= 2'b00;
            err_reg      <= 2'b00;
            udp_en_reg   <= 1'b0;
            in_data_reg  <= 8'h00;
            in_vld_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            port_reg     <= port_next;
            len_reg      <= len_next;
            csum_reg     <= csum_next;
            byte_cnt_reg <= byte_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            gnt_reg      <= gnt_next;
            err_reg      <= err_next;
            udp_en_reg   <= udp_en_next;
            in_data_reg  <= in_data_next;
            in_vld_reg   <= in_vld_next;
        end
    end

    // Read strobe is combinational so the source pops in the same cycle the coder asks.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign bus.SRC_RD[gi] = rd_any && (owner_reg == 1'(gi));
        end
    endgenerate

    assign bus.SRC_GNT           = gnt_reg;
    assign bus.SRC_ERR           = err_reg;
    assign bus.UDP_EN            = udp_en_reg;
    assign bus.UDP_HEADER        = {48'h0, port_reg};
    assign bus.IN_DATA_LENGTH    = len_reg;
    assign bus.UDP_DATA_CHECKSUM = csum_reg;
    assign bus.IN_DATA           = in_data_reg;
    assign bus.IN_DATA_VLD       = in_vld_reg;
    assign bus.BUSY              = (state_reg != S_IDLE);
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: arbitration order, streaming timing,
// zero-length and oversize requests, done timeout and mid-frame reset.
module tb_udp_tx_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_tx_scheduler_if bus ();

    udp_tx_scheduler dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  head0, head1;
    logic [1:0]  f_gnt, f_gnt_after, f_err;
    logic        f_en_at_gnt, f_en;
    logic [15:0] f_rd_mask, f_vld_mask;
    logic [31:0] f_cap;
    logic [7:0]  f_tail;
    int          f_busy, f_tmo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: account for the FWFT pop seen at the coming edge, then move to
    // the next falling edge, present the source heads and let logic settle.
    task automatic cyc();
        #1;
        if (bus.SRC_RD[0]) head0 = head0 + 8'd1;
        if (bus.SRC_RD[1]) head1 = head1 + 8'd1;
        @(negedge clk);
        bus.SRC_DATA0 = head0;
        bus.SRC_DATA1 = head1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.SRC_REQ = 2'b00;
        bus.UDP_DATA_REQUEST = 1'b0;
        bus.UDP_DONE = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    // Serve one frame as the coder would; results land in the f_* variables.
    task automatic serve(input bit withhold);
        int t;
        f_gnt = 2'b00; f_err = 2'b00; f_rd_mask = '0; f_vld_mask = '0;
        f_cap = '0; f_tail = 8'hFF; f_busy = 0; f_tmo = 0;
        t = 0;
        do begin
            cyc();
            t++;
        end while (bus.SRC_GNT == 2'b00 && t < 20);
        f_gnt = bus.SRC_GNT;
        f_en_at_gnt = bus.UDP_EN;
        bus.SRC_REQ = bus.SRC_REQ & ~f_gnt;
        cyc();
        f_en = bus.UDP_EN;
        f_gnt_after = bus.SRC_GNT;
        cyc();
        bus.UDP_DATA_REQUEST = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            f_rd_mask[i]  = |bus.SRC_RD;
            f_vld_mask[i] = bus.IN_DATA_VLD;
            if (bus.IN_DATA_VLD) f_cap = {bus.IN_DATA, f_cap[31:8]};
            if (i > 0 && f_vld_mask[i-1] && !bus.IN_DATA_VLD) f_tail = bus.IN_DATA;
            cyc();
            bus.UDP_DATA_REQUEST = 1'b0;
        end
        if (!withhold) begin
            bus.UDP_DONE = 1'b1;
            cyc();
            bus.UDP_DONE = 1'b0;
        end else begin
            t = 0;
            while (bus.SRC_ERR == 2'b00 && t < 2200) begin
                cyc();
                t++;
            end
            f_err = bus.SRC_ERR;
            f_tmo = t + 16;
        end
        while (bus.BUSY && f_busy < 100) begin
            f_busy++;
            cyc();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_order [4];
        int t;
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
        head0 = 8'hA0; head1 = 8'hB0;
        bus.SRC_DST_PORT0 = 16'h0; bus.SRC_DST_PORT1 = 16'h0;
        bus.SRC_LEN0 = 16'h0; bus.SRC_LEN1 = 16'h0;
        bus.SRC_CSUM0 = 16'h0; bus.SRC_CSUM1 = 16'h0;
        bus.SRC_DATA0 = 8'h0; bus.SRC_DATA1 = 8'h0;
        do_reset();
        cyc();

        check("rst_gnt", bus.SRC_GNT, 2'b00);
        check("rst_rd", bus.SRC_RD, 2'b00);
        check("rst_err", bus.SRC_ERR, 2'b00);
        check("rst_en", bus.UDP_EN, 1'b0);
        check("rst_hdr", bus.UDP_HEADER, 64'h0);
        check("rst_len", bus.IN_DATA_LENGTH, 16'h0);
        check("rst_csum", bus.UDP_DATA_CHECKSUM, 16'h0);
        check("rst_data", bus.IN_DATA, 8'h0);
        check("rst_vld", bus.IN_DATA_VLD, 1'b0);
        check("rst_busy", bus.BUSY, 1'b0);

        // 1) single source, 4 bytes
        bus.SRC_DST_PORT0 = 16'h2712; bus.SRC_LEN0 = 16'd4; bus.SRC_CSUM0 = 16'hABCD;
        bus.SRC_REQ = 2'b01;
        serve(1'b0);
        check("t1_gnt", f_gnt, 2'b01);
        check("t1_en_at_gnt", f_en_at_gnt, 1'b0);
        check("t1_en_next", f_en, 1'b1);
        check("t1_gnt_pulse", f_gnt_after, 2'b00);
        check("t1_rd_mask", f_rd_mask, 16'h000F);
        check("t1_vld_mask", f_vld_mask, 16'h001E);
        check("t1_bytes", f_cap, 32'hA3A2A1A0);
        check("t1_tail", f_tail, 8'h00);
        check("t1_gap_busy", f_busy, 13);
        check("t1_hdr", bus.UDP_HEADER, 64'h2712);
        check("t1_len", bus.IN_DATA_LENGTH, 16'd4);
        check("t1_csum", bus.UDP_DATA_CHECKSUM, 16'hABCD);

        // 2) both requesting from reset alternate starting at SRC0
        do_reset();
        bus.SRC_LEN0 = 16'd2; bus.SRC_LEN1 = 16'd2;
        for (int k = 0; k < 4; k++) begin
            bus.SRC_REQ = 2'b11;
            serve(1'b0);
            check($sformatf("t2_order%0d", k), f_gnt, exp_order[k]);
            check($sformatf("t2_rd%0d", k), f_rd_mask, 16'h0003);
        end

        // 3) zero-length frame from SRC1
        bus.SRC_LEN1 = 16'd0; bus.SRC_DST_PORT1 = 16'h0035;
        bus.SRC_REQ = 2'b10;
        serve(1'b0);
        check("t3_gnt", f_gnt, 2'b10);
        check("t3_en", f_en, 1'b1);
        check("t3_rd_mask", f_rd_mask, 16'h0000);
        check("t3_vld_mask", f_vld_mask, 16'h0000);
        check("t3_gap_busy", f_busy, 13);
        check("t3_hdr", bus.UDP_HEADER, 64'h0035);

        // 4) oversize SRC0 rejected, pending SRC1 served next
        bus.SRC_LEN0 = 16'd1473; bus.SRC_LEN1 = 16'd2;
        bus.SRC_REQ = 2'b11;
        t = 0;
        do begin
            cyc();
            t++;
        end while (bus.SRC_GNT == 2'b00 && t < 20);
        check("t4_gnt", bus.SRC_GNT, 2'b01);
        check("t4_err", bus.SRC_ERR, 2'b01);
        bus.SRC_REQ = 2'b10;
        cyc();
        check("t4_no_en", bus.UDP_EN, 1'b0);
        check("t4_idle", bus.BUSY, 1'b0);
        check("t4_err_pulse", bus.SRC_ERR, 2'b00);
        check("t4_len_kept", bus.IN_DATA_LENGTH, 16'd0);
        serve(1'b0);
        check("t4_next_gnt", f_gnt, 2'b10);
        check("t4_next_rd", f_rd_mask, 16'h0003);

        // 5) withheld UDP_DONE: one read cycle then DONE_TMO cycles in WAIT_DONE
        bus.SRC_LEN0 = 16'd1;
        bus.SRC_REQ = 2'b01;
        serve(1'b1);
        check("t5_gnt", f_gnt, 2'b01);
        check("t5_err", f_err, 2'b01);
        check("t5_tmo_cycles", f_tmo, 2048);
        check("t5_gap_busy", f_busy, 13);
        bus.SRC_LEN1 = 16'd3;
        bus.SRC_REQ = 2'b10;
        serve(1'b0);
        check("t5_next_gnt", f_gnt, 2'b10);
        check("t5_next_rd", f_rd_mask, 16'h0007);

        // 6) reset in the middle of a stream
        bus.SRC_LEN0 = 16'd8;
        bus.SRC_REQ = 2'b01;
        t = 0;
        do begin
            cyc();
            t++;
        end while (bus.SRC_GNT == 2'b00 && t < 20);
        check("t6_gnt", bus.SRC_GNT, 2'b01);
        bus.SRC_REQ = 2'b00;
        cyc();
        cyc();
        bus.UDP_DATA_REQUEST = 1'b1;
        cyc();
        bus.UDP_DATA_REQUEST = 1'b0;
        #1;
        check("t6_streaming", bus.SRC_RD, 2'b01);
        rst = 1'b1;
        cyc();
        check("t6_rd", bus.SRC_RD, 2'b00);
        check("t6_vld", bus.IN_DATA_VLD, 1'b0);
        check("t6_data", bus.IN_DATA, 8'h00);
        check("t6_hdr", bus.UDP_HEADER, 64'h0);
        check("t6_len", bus.IN_DATA_LENGTH, 16'h0);
        check("t6_csum", bus.UDP_DATA_CHECKSUM, 16'h0);
        check("t6_en", bus.UDP_EN, 1'b0);
        check("t6_busy", bus.BUSY, 1'b0);
        rst = 1'b0;
        bus.SRC_LEN0 = 16'd1; bus.SRC_LEN1 = 16'd1;
        bus.SRC_REQ = 2'b11;
        serve(1'b0);
        check("t6_ptr_src0", f_gnt, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
